// File: rtl/conv_acc_seq.sv
// conv_acc_seq: sequences KN kernel-position passes per output tile for the
// accumulator. It issues one acc_start per pass, counts the write beats that
// come back, and advances the kernel/tile indices until the job is done.
module conv_acc_seq #(
  parameter int AW = 11,
  parameter int KN = 9,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_base,
  input  logic [10:0]   cfg_size,
  input  logic [TW-1:0] cfg_tiles,
  input  logic          abort,
  input  logic          acc_m_valid,
  input  logic          acc_s_valid,
  output logic          acc_start,
  output logic [AW-1:0] acc_base2,
  output logic [10:0]   acc_size,
  output logic          acc_first_k,
  output logic          acc_last_k,
  output logic [3:0]    k_idx,
  output logic [TW-1:0] tile_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] K_LAST = 4'(KN - 1);

  state_t        state_q, state_d;
  logic [10:0]   size_q, size_d;
  logic [TW-1:0] tiles_q, tiles_d;
  logic [AW-1:0] tbase_q, tbase_d;   // base address of the current tile
  logic [10:0]   cnt_q, cnt_d;       // beats seen in the current pass
  logic [3:0]    k_q, k_d;
  logic [TW-1:0] tile_q, tile_d;
  logic          start_q, start_d;
  logic [AW-1:0] base2_q, base2_d;
  logic [10:0]   asize_q, asize_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          beat;
  logic          err_set;
  logic [10:0]   cnt_inc;

  assign beat    = acc_m_valid | acc_s_valid;
  assign cnt_inc = cnt_q + 11'd1;

  // A beat outside a job, a beat of the wrong kind for the kernel position,
  // or both beat kinds at once are all protocol errors.
  assign err_set = ((state_q == S_IDLE) && beat) ||
                   ((state_q != S_IDLE) && ((acc_s_valid && !last_q) || (acc_m_valid && last_q))) ||
                   (acc_m_valid && acc_s_valid);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    tiles_d = tiles_q;
    tbase_d = tbase_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    tile_d  = tile_q;
    base2_d = base2_q;
    asize_d = asize_q;
    first_d = first_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = err_q | err_set;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          size_d  = cfg_size;
          tiles_d = cfg_tiles;
          tbase_d = cfg_base;
          cnt_d   = '0;
          k_d     = '0;
          tile_d  = '0;
          err_d   = 1'b0;
          state_d = (cfg_size == 11'd0 || cfg_tiles == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (beat) begin
          if (cnt_inc == size_q) begin
            cnt_d = '0;
            if (k_q != K_LAST) begin
              k_d     = k_q + 4'd1;
              state_d = S_ISSUE;
            end else if (tile_q != tiles_q - TW'(1)) begin
              k_d     = '0;
              tile_d  = tile_q + TW'(1);
              tbase_d = tbase_q + AW'(size_q);
              state_d = S_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over everything else, including a pass end this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      k_d     = '0;
      tile_d  = '0;
      done_d  = 1'b0;
    end

    // Pass descriptors only change as a pass is launched, so they hold
    // steady for the whole ISSUE/WAIT window.
    start_d = (state_d == S_ISSUE);
    if (state_d == S_ISSUE) begin
      base2_d = tbase_d;
      asize_d = size_d;
      first_d = (k_d == 4'd0);
      last_d  = (k_d == K_LAST);
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      tiles_q <= '0;
      tbase_q <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      tile_q  <= '0;
      start_q <= 1'b0;
      base2_q <= '0;
      asize_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      tiles_q <= tiles_d;
      tbase_q <= tbase_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      tile_q  <= tile_d;
      start_q <= start_d;
      base2_q <= base2_d;
      asize_q <= asize_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign acc_start   = start_q;
  assign acc_base2   = base2_q;
  assign acc_size    = asize_q;
  assign acc_first_k = first_q;
  assign acc_last_k  = last_q;
  assign k_idx       = k_q;
  assign tile_idx    = tile_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_conv_acc_seq.sv
// Scoreboard bench for conv_acc_seq: the job model pushes the expected pass
// descriptors and done events; a monitor pops them as the DUT presents them.
module tb_conv_acc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [10:0] cfg_base;
  logic [10:0] cfg_size;
  logic [7:0]  cfg_tiles;
  logic        abort;
  logic        acc_m_valid;
  logic        acc_s_valid;
  logic        acc_start;
  logic [10:0] acc_base2;
  logic [10:0] acc_size;
  logic        acc_first_k;
  logic        acc_last_k;
  logic [3:0]  k_idx;
  logic [7:0]  tile_idx;
  logic        busy;
  logic        done;
  logic        err;

  conv_acc_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_size(cfg_size), .cfg_tiles(cfg_tiles), .abort(abort),
    .acc_m_valid(acc_m_valid), .acc_s_valid(acc_s_valid),
    .acc_start(acc_start), .acc_base2(acc_base2), .acc_size(acc_size),
    .acc_first_k(acc_first_k), .acc_last_k(acc_last_k), .k_idx(k_idx),
    .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] base2;
    logic [10:0] size;
    logic        first;
    logic        last;
    logic [3:0]  k;
    logic [7:0]  tile;
  } pass_t;

  pass_t exp_q[$];
  int    done_pend = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every pass launch and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_start) begin
        chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          pass_t e;
          e = exp_q.pop_front();
          chk("acc_base2", 32'(acc_base2), 32'(e.base2));
          chk("acc_size", 32'(acc_size), 32'(e.size));
          chk("acc_first_k", 32'(acc_first_k), 32'(e.first));
          chk("acc_last_k", 32'(acc_last_k), 32'(e.last));
          chk("k_idx", 32'(k_idx), 32'(e.k));
          chk("tile_idx", 32'(tile_idx), 32'(e.tile));
          chk("busy_in_pass", 32'(busy), 32'd1);
        end
      end
      if (done) begin
        chk("done_expected", 32'(done_pend > 0), 32'd1);
        if (done_pend > 0) done_pend--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (acc_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Model: a job is KN=9 passes per tile; pass p covers kernel p%9 of tile
  // p/9 and addresses base + tile*size modulo 2^11.
  task automatic push_passes(input logic [10:0] base, input logic [10:0] size, input int n);
    pass_t e;
    for (int p = 0; p < n; p++) begin
      e.k     = 4'(p % 9);
      e.tile  = 8'(p / 9);
      e.base2 = base + 11'((p / 9) * int'(size));
      e.size  = size;
      e.first = (p % 9 == 0);
      e.last  = (p % 9 == 8);
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input logic [10:0] base, input logic [10:0] size, input logic [7:0] tiles);
    tick();
    cfg_start = 1'b1; cfg_base = base; cfg_size = size; cfg_tiles = tiles;
    tick();
    cfg_start = 1'b0; cfg_base = 11'($urandom); cfg_size = 11'($urandom); cfg_tiles = 8'($urandom);
  endtask

  task automatic run_job(input logic [10:0] base, input logic [10:0] size, input logic [7:0] tiles,
                         input int abort_pass, input int bad_pass, input int both_pass, input bit mid_start);
    int npass, limit;
    bit ok, exp_err, m, s, lastk, ab;
    npass = (size == 0 || tiles == 0) ? 0 : 9 * int'(tiles);
    limit = (abort_pass > 0) ? abort_pass : npass;
    push_passes(base, size, limit);
    if (abort_pass == 0) done_pend++;
    exp_err = 1'b0;
    ab = 1'b0;
    launch(base, size, tiles);
    chk("err_clear", 32'(err), 32'd0);
    chk("busy_launch", 32'(busy), 32'd1);
    for (int p = 1; p <= limit && !ab; p++) begin
      wait_start(ok);
      chk("pass_start_seen", 32'(ok), 32'd1);
      if (!ok) break;
      tick();
      if (mid_start && p == 2) begin
        cfg_start = 1'b1; cfg_base = base ^ 11'h155; cfg_size = size + 11'd1; cfg_tiles = tiles + 8'd1;
        tick();
        cfg_start = 1'b0;
      end
      for (int b = 1; b <= int'(size); b++) begin
        repeat ($urandom_range(0, 2)) tick();
        lastk = ((p - 1) % 9 == 8);
        m = !lastk;
        s = lastk;
        if (p == bad_pass && b == 1) begin m = 1'b0; s = 1'b1; exp_err = 1'b1; end
        if (p == both_pass && b == 2) begin m = 1'b1; s = 1'b1; exp_err = 1'b1; end
        ab = (p == abort_pass && b == 2);
        acc_m_valid = m; acc_s_valid = s; abort = ab;
        tick();
        acc_m_valid = 1'b0; acc_s_valid = 1'b0; abort = 1'b0;
        if (ab) break;
      end
    end
    if (abort_pass > 0) begin
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_k_idx", 32'(k_idx), 32'd0);
      repeat (6) tick();
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done_pend == 0) begin ok = 1'b1; break; end
      end
      chk("done_seen", 32'(ok), 32'd1);
      tick();
      chk("busy_end", 32'(busy), 32'd0);
    end
    chk("err_end", 32'(err), 32'(exp_err));
  endtask

  // Empty job: straight to DONE with no pass launches.
  task automatic zero_job(input logic [10:0] size, input logic [7:0] tiles);
    done_pend++;
    launch(11'h123, size, tiles);
    chk("zero_busy1", 32'(busy), 32'd1);
    chk("zero_done1", 32'(done), 32'd0);
    tick();
    chk("zero_busy2", 32'(busy), 32'd0);
    chk("zero_done2", 32'(done), 32'd1);
    tick();
    chk("zero_done3", 32'(done), 32'd0);
    chk("zero_pend", 32'(done_pend), 32'd0);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_size = '0; cfg_tiles = '0;
    abort = 1'b0; acc_m_valid = 1'b0; acc_s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc_start", 32'(acc_start), 32'd0);
    chk("rst_base2", 32'(acc_base2), 32'd0);
    chk("rst_size", 32'(acc_size), 32'd0);
    chk("rst_first_k", 32'(acc_first_k), 32'd0);
    chk("rst_last_k", 32'(acc_last_k), 32'd0);
    chk("rst_k_idx", 32'(k_idx), 32'd0);
    chk("rst_tile_idx", 32'(tile_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    run_job(11'h010, 11'd4, 8'd1, 0, 0, 0, 1'b0);
    run_job(11'h7F8, 11'd8, 8'd3, 0, 0, 0, 1'b0);
    for (int j = 0; j < 4; j++)
      run_job(11'($urandom), 11'($urandom_range(1, 5)), 8'($urandom_range(1, 3)), 0, 0, 0, 1'b0);
    zero_job(11'd0, 8'd2);
    zero_job(11'd5, 8'd0);
    run_job(11'h200, 11'd4, 8'd2, 5, 0, 0, 1'b0);
    run_job(11'h040, 11'd3, 8'd1, 0, 0, 0, 1'b0);
    run_job(11'h100, 11'd4, 8'd1, 0, 3, 5, 1'b0);
    run_job(11'h300, 11'd2, 8'd2, 0, 0, 0, 1'b1);

    // Beat with no job running.
    tick();
    acc_m_valid = 1'b1;
    tick();
    acc_m_valid = 1'b0;
    chk("idle_beat_err", 32'(err), 32'd1);

    // Reset in the middle of a job discards it.
    push_passes(11'h055, 11'd4, 1);
    launch(11'h055, 11'd4, 8'd1);
    wait_start(ok);
    chk("rst_job_start", 32'(ok), 32'd1);
    tick();
    acc_m_valid = 1'b1;
    tick();
    acc_m_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_k_idx", 32'(k_idx), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pend_end", 32'(done_pend), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_acc_seq.md
CONV_ACC_SEQ -- requirements
Module: conv_acc_seq

Interface
REQ-001 Parameter AW, default 11: accumulator buffer address width.
REQ-002 Parameter KN, default 9: kernel positions per output tile (3x3).
REQ-003 Parameter TW, default 8: tile-count width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_start  input  1  one-cycle job launch request.
REQ-007 cfg_base  input  AW  buffer base address of tile 0.
REQ-008 cfg_size  input  11  beats per pass (words per tile).
REQ-009 cfg_tiles  input  TW  number of output tiles.
REQ-010 abort  input  1  synchronous job cancel.
REQ-011 acc_m_valid  input  1  accumulator partial-sum write beat.
REQ-012 acc_s_valid  input  1  accumulator final-sum write beat.
REQ-013 acc_start  output  1  one-cycle pass launch to accumulator.
REQ-014 acc_base2  output  AW  bias/partial-sum base for current pass.
REQ-015 acc_size  output  11  beats in current pass.
REQ-016 acc_first_k  output  1  high for kernel position 0.
REQ-017 acc_last_k  output  1  high for kernel position KN-1.
REQ-018 k_idx  output  4  current kernel position, for weight fetch.
REQ-019 tile_idx  output  TW  current tile.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 done  output  1  one-cycle job-complete pulse.
REQ-022 err  output  1  sticky protocol-error flag.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-024 IDLE: cfg_start=1 latches cfg_base/size/tiles, clears err, k_idx=0, tile_idx=0; next state ISSUE, or DONE if cfg_size=0 or cfg_tiles=0 (no acc_start then).
REQ-025 cfg_start while busy=1 is ignored; latched config is unchanged.
REQ-026 ISSUE: acc_start=1 exactly one cycle; next state WAIT.
REQ-027 acc_base2 = latched base + tile_idx*size (AW bits, wraps modulo 2^AW); acc_size, acc_base2, acc_first_k, acc_last_k stable from ISSUE through end of WAIT.
REQ-028 acc_first_k = (k_idx==0); acc_last_k = (k_idx==KN-1); both 1 when KN=1.
REQ-029 WAIT: 11-bit beat counter increments on each cycle with acc_m_valid|acc_s_valid; both high in one cycle counts one beat and sets err.
REQ-030 Pass ends on the beat that makes count==size; counter clears.
REQ-031 Pass end with k_idx<KN-1: k_idx+1, next ISSUE.
REQ-032 Pass end with k_idx=KN-1, tile_idx<tiles-1: k_idx=0, tile_idx+1, next ISSUE.
REQ-033 Pass end with k_idx=KN-1, tile_idx=tiles-1: next DONE.
REQ-034 Minimum pass-to-pass gap: acc_start pulses at least 2 cycles apart (ISSUE, >=1 WAIT).
REQ-035 DONE: done=1 one cycle, then IDLE; busy=0 in the IDLE cycle after.
REQ-036 err set on: acc_s_valid while acc_last_k=0, acc_m_valid while acc_last_k=1, or any beat in IDLE; cleared only by reset or accepted cfg_start.
REQ-037 abort=1 in any non-IDLE state: next state IDLE, no done, counters cleared; abort has priority over pass-end and cfg_start.
REQ-038 Beats arriving after abort are ignored except err per REQ-036.

Reset
REQ-039 rst_n low: state IDLE; acc_start, acc_base2, acc_size, acc_first_k, acc_last_k, k_idx, tile_idx, busy, done, err, beat counter all 0.
REQ-040 rst_n assertion mid-job discards the job immediately; no done follows.

Verification
REQ-041 base=0x010, size=4, tiles=1, KN=9, 4 m_valid beats/pass (s_valid on pass 9) -> 9 acc_start pulses, first_k only on pass 1, last_k only on pass 9, acc_base2=0x010 each pass, one done, err=0.
REQ-042 base=0x7F8, size=8, tiles=3 -> acc_base2 0x7F8, 0x000, 0x008 (wrap), 27 passes, tile_idx 0..2, one done.
REQ-043 cfg_size=0 -> no acc_start, done 2 cycles after cfg_start, busy high 1 cycle.
REQ-044 abort on beat 2 of pass 5 -> IDLE next cycle, busy=0, no done; new cfg_start afterwards restarts at k_idx=0.
REQ-045 acc_s_valid during pass 3, and m_valid+s_valid same cycle -> err=1 and held until next cfg_start; beat counted once.
REQ-046 cfg_start pulsed mid-job with different cfg_base -> ignored; job completes with original addresses.
